// File: rtl/result_requant_drain_pkg.sv
// Shared types, fixed-point width constants and the per-element requantization
// function for the systolic array result drain.
package result_requant_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int ACC_W    = 32;  // accumulator width
    localparam int ACT_W    = 16;  // S5.10 activation width
    localparam int ACT_FRAC = 10;
    localparam int WGT_FRAC = 6;   // S1.6 weight fraction bits
    localparam int ACC_FRAC = ACT_FRAC + WGT_FRAC;
    localparam int MAX_W    = 64;  // widest accumulator the function handles

    typedef struct packed {
        logic signed [MAX_W:0] value;
        logic                  sat;
    } requant_t;

    // Round half toward +inf (optional), arithmetic shift, clamp to out_width.
    function automatic requant_t requant(input logic signed [MAX_W-1:0] acc,
                                         input int                      frac_shift,
                                         input logic                    round_en,
                                         input int                      out_width);
        logic signed [MAX_W:0] ext;
        logic signed [MAX_W:0] rnd;
        logic signed [MAX_W:0] shifted;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        requant_t              r;
        ext = {acc[MAX_W-1], acc};
        rnd = '0;
        if (round_en) begin
            rnd = (MAX_W+1)'(1) << (frac_shift - 1);
        end
        shifted = (ext + rnd) >>> frac_shift;
        hi      = ((MAX_W+1)'(1) << (out_width - 1)) - (MAX_W+1)'(1);
        lo      = -hi - (MAX_W+1)'(1);
        r.sat   = 1'b1;
        if (shifted > hi) begin
            r.value = hi;
        end else if (shifted < lo) begin
            r.value = lo;
        end else begin
            r.value = shifted;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_requant_drain_requant_sat.sv
// Single-element round/shift/saturate stage; purely combinational.
module requant_sat
    import result_requant_drain_pkg::*;
#(
    parameter int ACCUM_WIDTH = ACC_W,
    parameter int OUT_WIDTH   = ACT_W,
    parameter int FRAC_SHIFT  = ACC_FRAC - ACT_FRAC,
    parameter int ROUND_EN    = 1
) (
    input  logic [ACCUM_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0]   q,
    output logic                   sat
);

    logic signed [MAX_W-1:0] acc_ext;
    requant_t                r;

    always_comb begin
        acc_ext = MAX_W'(signed'(acc));
        r       = requant(acc_ext, FRAC_SHIFT, 1'(ROUND_EN), OUT_WIDTH);
        q       = r.value[OUT_WIDTH-1:0];
        sat     = r.sat;
        // Above OUT_WIDTH the clamped value is nothing but sign extension.
        assert (r.value == (MAX_W+1)'(signed'(q)));
    end

endmodule

// File: rtl/result_requant_drain.sv
// Captures an accumulator tile from the systolic array and streams it out one
// requantized S5.10 row per valid/ready beat.
module result_requant_drain
    import result_requant_drain_pkg::*;
#(
    parameter int ARRAY_SIZE  = 4,
    parameter int ACCUM_WIDTH = ACC_W,
    parameter int OUT_WIDTH   = ACT_W,
    parameter int FRAC_SHIFT  = ACC_FRAC - ACT_FRAC,
    parameter int ROUND_EN    = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
    input  logic                                       result_valid,
    output logic                                       capture_ready,
    output logic [OUT_WIDTH*ARRAY_SIZE-1:0]            out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]              out_row_idx,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last,
    output logic                                       tile_done,
    output logic                                       tile_sat,
    output logic                                       overrun,
    output state_t                                     dbg_state
);

    // Handshake: a beat transfers on a rising edge with out_valid && out_ready;
    // while out_ready is low the presented beat (data, index, last) is frozen and
    // out_valid stays high. The producer may only pulse result_valid while
    // capture_ready is high; any other pulse is dropped and flagged in overrun.

    localparam int IDX_W  = $clog2(ARRAY_SIZE);
    localparam int ROW_W  = ACCUM_WIDTH * ARRAY_SIZE;
    localparam int TILE_W = ROW_W * ARRAY_SIZE;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARRAY_SIZE - 1);

    state_t            state_q, state_d;
    logic [TILE_W-1:0] tile_q;
    logic [IDX_W-1:0]  row_ptr_q;
    logic              tile_sat_q;
    logic              overrun_q;
    logic              capture;
    logic              accept;
    logic [ROW_W-1:0]  row_acc;
    logic [ARRAY_SIZE-1:0] row_sat;

    assign row_acc     = tile_q[int'(row_ptr_q)*ROW_W +: ROW_W];
    assign out_row_idx = row_ptr_q;
    assign tile_sat    = tile_sat_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        requant_sat #(
            .ACCUM_WIDTH (ACCUM_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .FRAC_SHIFT  (FRAC_SHIFT),
            .ROUND_EN    (ROUND_EN)
        ) u_requant_sat (
            .acc (row_acc[c*ACCUM_WIDTH +: ACCUM_WIDTH]),
            .q   (out_data[c*OUT_WIDTH +: OUT_WIDTH]),
            .sat (row_sat[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        accept        = 1'b0;
        capture_ready = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        tile_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                capture_ready = 1'b1;
                if (result_valid) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_last  = (row_ptr_q == LAST_ROW);
                accept    = out_ready;
                if (out_ready && (row_ptr_q == LAST_ROW)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                tile_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row pointer wraps back to 0 after the last row, ready for the next tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_q     <= '0;
            row_ptr_q  <= '0;
            tile_sat_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (capture) begin
                tile_q     <= result_flat;
                row_ptr_q  <= '0;
                tile_sat_q <= 1'b0;
            end else if (accept) begin
                row_ptr_q  <= row_ptr_q + 1'b1;
                tile_sat_q <= tile_sat_q | (|row_sat);
            end
            if (result_valid && !capture_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_requant_drain.sv
// Directed bench for result_requant_drain: streaming order, rounding,
// saturation, backpressure, overrun and mid-stream reset.
module tb_result_requant_drain;
    import result_requant_drain_pkg::*;

    localparam int N      = 4;
    localparam int AW     = 32;
    localparam int OW     = 16;
    localparam int TILE_W = N * N * AW;
    localparam int ROW_O  = N * OW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [TILE_W-1:0] result_flat = '0;
    logic              result_valid = 1'b0;
    logic              out_ready = 1'b1;

    logic              capture_ready, out_valid, out_last, tile_done, tile_sat, overrun;
    logic [ROW_O-1:0]  out_data;
    logic [1:0]        out_row_idx;
    state_t            dbg_state;

    logic              t_capture_ready, t_out_valid, t_out_last, t_tile_done, t_tile_sat, t_overrun;
    logic [ROW_O-1:0]  t_out_data;
    logic [1:0]        t_out_row_idx;
    state_t            t_dbg_state;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [ROW_O-1:0]  exp_q[$];
    logic [ROW_O-1:0]  exp_t_q[$];
    logic [AW-1:0]     el[N*N];

    result_requant_drain u_dut (
        .clk           (clk),
        .rst           (rst),
        .result_flat   (result_flat),
        .result_valid  (result_valid),
        .capture_ready (capture_ready),
        .out_data      (out_data),
        .out_row_idx   (out_row_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .tile_done     (tile_done),
        .tile_sat      (tile_sat),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    result_requant_drain #(.ROUND_EN(0)) u_dut_trunc (
        .clk           (clk),
        .rst           (rst),
        .result_flat   (result_flat),
        .result_valid  (result_valid),
        .capture_ready (t_capture_ready),
        .out_data      (t_out_data),
        .out_row_idx   (t_out_row_idx),
        .out_valid     (t_out_valid),
        .out_ready     (out_ready),
        .out_last      (t_out_last),
        .tile_done     (t_tile_done),
        .tile_sat      (t_tile_sat),
        .overrun       (t_overrun),
        .dbg_state     (t_dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] row4(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Drivers: everything is driven and sampled on the falling edge.
    task automatic clear_el();
        for (int i = 0; i < N*N; i++) el[i] = '0;
    endtask

    task automatic start_tile();
        for (int i = 0; i < N*N; i++) result_flat[i*AW +: AW] = el[i];
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic drain_tile(input int sat_row, input int stall_row, input int stall_n,
                              input int ovr_row);
        logic [63:0] exp_row;
        logic [63:0] exp_t;
        logic        has_t;
        check_eq("tile_sat_cleared", tile_sat, 0);
        for (int r = 0; r < N; r++) begin
            exp_row = exp_q.pop_front();
            has_t   = exp_t_q.size() > 0;
            exp_t   = has_t ? exp_t_q.pop_front() : '0;
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_idx", out_row_idx, r);
                    check_eq("stall_data", out_data, exp_row);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check_eq("beat_valid", out_valid, 1);
            check_eq("beat_idx", out_row_idx, r);
            check_eq("beat_data", out_data, exp_row);
            check_eq("beat_last", out_last, r == N-1);
            if (has_t) check_eq("trunc_data", t_out_data, exp_t);
            if (r == ovr_row) begin
                result_flat  = ~result_flat;
                result_valid = 1'b1;
            end
            @(negedge clk);
            result_valid = 1'b0;
            check_eq("tile_sat", tile_sat, (sat_row >= 0) && (r >= sat_row));
            if (r == ovr_row) check_eq("overrun_set", overrun, 1);
        end
        check_eq("done_pulse", tile_done, 1);
        check_eq("done_valid", out_valid, 0);
        check_eq("done_ready", capture_ready, 0);
        @(negedge clk);
        check_eq("idle_done", tile_done, 0);
        check_eq("idle_ready", capture_ready, 1);
    endtask

    task automatic load_ramp(input int base);
        clear_el();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) el[r*N+c] = AW'((base + r*N + c) << 6);
            exp_q.push_back(row4(16'(base + r*N), 16'(base + r*N + 1),
                                 16'(base + r*N + 2), 16'(base + r*N + 3)));
        end
    endtask

    logic [31:0] sat_in[3]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h001F_FFE0};
    logic [15:0] sat_exp[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] sat_trc[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", capture_ready, 1);
        check_eq("rst_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("init_state", dbg_state, ST_IDLE);
        check_eq("init_valid", out_valid, 0);
        check_eq("init_last", out_last, 0);
        check_eq("init_done", tile_done, 0);
        check_eq("init_sat", tile_sat, 0);
        check_eq("init_overrun", overrun, 0);
        check_eq("init_idx", out_row_idx, 0);
        check_eq("init_data", out_data, 0);

        // Ramp tile, full-speed drain
        load_ramp(0);
        start_tile();
        drain_tile(-1, -1, 0, -1);

        // Rounding corners; the truncating instance sees the same tile
        clear_el();
        el[0] = 32'h0000_0020; el[1] = 32'h0000_001F;
        el[2] = 32'hFFFF_FFE0; el[3] = 32'hFFFF_FFDF;
        el[4] = 32'h001F_FFC0; el[8] = 32'h0000_003F;
        exp_q.push_back(row4(16'h0001, 16'h0000, 16'h0000, 16'hFFFF));
        exp_q.push_back(row4(16'h7FFF, 16'h0000, 16'h0000, 16'h0000));
        exp_q.push_back(row4(16'h0001, 16'h0000, 16'h0000, 16'h0000));
        exp_q.push_back('0);
        exp_t_q.push_back(row4(16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF));
        exp_t_q.push_back(row4(16'h7FFF, 16'h0000, 16'h0000, 16'h0000));
        exp_t_q.push_back('0);
        exp_t_q.push_back('0);
        start_tile();
        drain_tile(-1, -1, 0, -1);

        // Saturation: one clamping element in row 2, column 1
        for (int i = 0; i < 3; i++) begin
            clear_el();
            el[2*N+1] = sat_in[i];
            exp_q.push_back('0);
            exp_q.push_back('0);
            exp_q.push_back(row4(16'h0, sat_exp[i], 16'h0, 16'h0));
            exp_q.push_back('0);
            exp_t_q.push_back('0);
            exp_t_q.push_back('0);
            exp_t_q.push_back(row4(16'h0, sat_trc[i], 16'h0, 16'h0));
            exp_t_q.push_back('0);
            start_tile();
            drain_tile(2, -1, 0, -1);
        end

        // Backpressure on row 1 for three cycles
        load_ramp(16);
        start_tile();
        drain_tile(-1, 1, 3, -1);

        // Overrun while row 2 is presented
        check_eq("overrun_clear", overrun, 0);
        load_ramp(40);
        start_tile();
        drain_tile(-1, -1, 0, 2);
        check_eq("overrun_sticky", overrun, 1);

        // Reset after row 1 accepted
        load_ramp(60);
        exp_q.delete();
        start_tile();
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_idx", out_row_idx, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("async_valid", out_valid, 0);
        check_eq("async_ready", capture_ready, 1);
        check_eq("async_overrun", overrun, 0);
        check_eq("async_done", tile_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_done", tile_done, 0);
        load_ramp(100);
        start_tile();
        drain_tile(-1, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
